// File: rtl/boot_pkg.sv
// boot_pkg: shared loader state encoding and frame constants
package boot_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} boot_state_t;
  localparam int BOOT_ADDR_W = 13;
  localparam int BOOT_DATA_W = 8;
  localparam logic [7:0] BOOT_SYNC = 8'hA5;
  localparam logic [12:0] BOOT_MAX_LEN = 13'h1FFF;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream, memory write port and CPU control of the boot loader
interface boot_loader_if import boot_pkg::*; #(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W
) ();
  logic boot_start;
  logic rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_wr;
  logic mem_sel;
  logic cpu_rst_n;
  logic load_busy;
  logic load_err;
  modport master (
    input boot_start, rx_valid, rx_data,
    output rx_ready, mem_addr, mem_wdata, mem_wr, mem_sel, cpu_rst_n, load_busy, load_err
  );
  modport slave (
    output boot_start, rx_valid, rx_data,
    input rx_ready, mem_addr, mem_wdata, mem_wr, mem_sel, cpu_rst_n, load_busy, load_err
  );
endinterface

// File: rtl/boot_wr_strobe.sv
// boot_wr_strobe: loadable down-counter producing the WR_CYCLES-long mem_wr pulse
module boot_wr_strobe #(
  parameter int WR_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic abort,
  output logic wr,
  output logic done
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= abort ? 4'd0 : load ? 4'(WR_CYCLES) : (cnt != 4'd0) ? cnt - 4'd1 : cnt;
  assign wr = cnt != 4'd0;
  assign done = cnt == 4'd1;
endmodule

// File: rtl/boot_loader.sv
// boot_loader: framed image loader holding the CPU in reset; BOOT_TIMEOUT_EN adds an inter-byte timeout
module boot_loader import boot_pkg::*; #(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE = BOOT_SYNC,
  parameter int WR_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic reset,
  boot_loader_if.master bus
);
  boot_state_t state;
  logic [ADDR_W-1:0] len, addr_cnt;
  logic [DATA_W-1:0] csum;
  logic xfer, wr_load, wr_done, wr_busy, tmo;
  assign xfer = bus.rx_valid & bus.rx_ready;
  assign wr_load = xfer & (state == DATA) & ~bus.boot_start;
  assign bus.mem_wr = wr_busy;
  boot_wr_strobe #(.WR_CYCLES(WR_CYCLES)) u_strobe (
    .clk(clk), .reset(reset), .load(wr_load), .abort(bus.boot_start), .wr(wr_busy), .done(wr_done)
  );
`ifdef BOOT_TIMEOUT_EN
  logic [15:0] tcnt;
  // every state entry into a counted state coincides with a transfer or a write, so those clears cover entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else if (bus.boot_start | xfer | wr_busy | !(state inside {LEN_HI, LEN_LO, DATA, CSUM})) tcnt <= '0;
    else if (!tmo) tcnt <= tcnt + 16'd1;
  assign tmo = tcnt == 16'(TIMEOUT_CYCLES);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_sel <= 1'b1;
      bus.cpu_rst_n <= 1'b0;
      bus.load_busy <= 1'b0;
      bus.load_err <= 1'b0;
      len <= '0;
      addr_cnt <= '0;
      csum <= '0;
    end else if (bus.boot_start) begin
      state <= IDLE;
      bus.rx_ready <= 1'b1;
      bus.mem_sel <= 1'b1;
      bus.cpu_rst_n <= 1'b0;
      bus.load_busy <= 1'b0;
      bus.load_err <= 1'b0;
    end else if (tmo) begin
      state <= ERROR;
      bus.rx_ready <= 1'b0;
      bus.load_busy <= 1'b0;
      bus.load_err <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.rx_ready <= 1'b1;
          if (xfer && bus.rx_data == SYNC_BYTE) begin
            state <= LEN_HI;
            bus.load_busy <= 1'b1;
          end
        end
        LEN_HI: if (xfer) begin
          len <= {bus.rx_data[ADDR_W-DATA_W-1:0], len[DATA_W-1:0]};
          if (|bus.rx_data[DATA_W-1:ADDR_W-DATA_W]) begin
            state <= ERROR;
            bus.rx_ready <= 1'b0;
            bus.load_busy <= 1'b0;
            bus.load_err <= 1'b1;
          end else state <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          len[DATA_W-1:0] <= bus.rx_data;
          csum <= '0;
          addr_cnt <= '0;
          state <= ({len[ADDR_W-1:DATA_W], bus.rx_data} == '0) ? CSUM : DATA;
        end
        DATA: if (xfer) begin
          bus.mem_wdata <= bus.rx_data;
          bus.mem_addr <= addr_cnt;
          csum <= csum + bus.rx_data;
          bus.rx_ready <= 1'b0;
        end else if (wr_done) begin
          bus.rx_ready <= 1'b1;
          addr_cnt <= addr_cnt + 1'b1;
          if (addr_cnt == len - 1'b1) state <= CSUM;
        end
        CSUM: if (xfer) begin
          bus.rx_ready <= 1'b0;
          bus.load_busy <= 1'b0;
          if (bus.rx_data == csum) begin
            state <= DONE;
            bus.mem_sel <= 1'b0;
            bus.cpu_rst_n <= 1'b1;
          end else begin
            state <= ERROR;
            bus.load_err <= 1'b1;
          end
        end
        DONE, ERROR: ;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frame tests on WR_CYCLES=1 and WR_CYCLES=3 instances
module tb_boot_loader;
`ifdef BOOT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 65535;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [12:0] wa[$];
  logic [7:0] wd[$];

  boot_loader_if b1();
  boot_loader_if b3();
  boot_loader #(.WR_CYCLES(1), .TIMEOUT_CYCLES(TO)) u1 (.clk(clk), .reset(reset), .bus(b1));
  boot_loader #(.WR_CYCLES(3), .TIMEOUT_CYCLES(TO)) u3 (.clk(clk), .reset(reset), .bus(b3));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (b1.mem_wr === 1'b1) begin
      wa.push_back(b1.mem_addr);
      wd.push_back(b1.mem_wdata);
    end

  task automatic restart(input bit s);
    if (s) b3.boot_start = 1'b1; else b1.boot_start = 1'b1;
    @(negedge clk);
    b1.boot_start = 1'b0;
    b3.boot_start = 1'b0;
  endtask

  task automatic send(input bit s, input logic [7:0] d);
    int n = 0;
    if (s) begin b3.rx_data = d; b3.rx_valid = 1'b1; end
    else begin b1.rx_data = d; b1.rx_valid = 1'b1; end
    while ((s ? b3.rx_ready : b1.rx_ready) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 50) begin errors++; $display("FAIL send_wait: rx_ready=0 for 50 cycles on byte %h, want 1", d); end
    @(negedge clk);
    b1.rx_valid = 1'b0;
    b3.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    b1.boot_start = 0; b1.rx_valid = 0; b1.rx_data = 0;
    b3.boot_start = 0; b3.rx_valid = 0; b3.rx_data = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b1.cpu_rst_n, b1.mem_sel, b1.mem_wr, b1.rx_ready, b1.load_busy, b1.load_err} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 010000", {b1.cpu_rst_n, b1.mem_sel, b1.mem_wr, b1.rx_ready, b1.load_busy, b1.load_err});
    end
    checks++;
    if (b1.mem_addr !== 13'h0 || b1.mem_wdata !== 8'h0) begin
      errors++; $display("FAIL reset_mem: got addr %h data %h want 0 0", b1.mem_addr, b1.mem_wdata);
    end
    reset = 1'b1;
    checks++;
    if (b1.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b want 0", b1.rx_ready); end
    @(negedge clk);
    checks++;
    if (b1.rx_ready !== 1'b1 || b3.rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_post: got %b/%b want 1/1", b1.rx_ready, b3.rx_ready);
    end
  endtask

  task automatic test_good_frame;
    int base;
    logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
    restart(0);
    base = wa.size();
    send(0, 8'hA5);
    checks++;
    if (b1.load_busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b want 1", b1.load_busy); end
    send(0, 8'h00); send(0, 8'h03); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h66);
    checks++;
    if (wa.size() - base != 3) begin errors++; $display("FAIL good_wr_count: got %0d want 3", wa.size() - base); end
    else for (int k = 0; k < 3; k++) begin
      checks++;
      if (wa[base+k] !== 13'(k) || wd[base+k] !== exp_d[k]) begin
        errors++; $display("FAIL good_write%0d: got %h@%h want %h@%h", k, wd[base+k], wa[base+k], exp_d[k], 13'(k));
      end
    end
    @(negedge clk);
    checks++;
    if ({b1.cpu_rst_n, b1.mem_sel, b1.load_err, b1.rx_ready, b1.load_busy} !== 5'b10000) begin
      errors++;
      $display("FAIL good_done: rst_n/sel/err/rdy/busy got %b want 10000", {b1.cpu_rst_n, b1.mem_sel, b1.load_err, b1.rx_ready, b1.load_busy});
    end
  endtask

  task automatic test_bad_csum;
    int base;
    restart(0);
    checks++;
    if (b1.mem_sel !== 1'b1 || b1.cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL restart_ctrl: sel/rst_n got %b%b want 10", b1.mem_sel, b1.cpu_rst_n);
    end
    base = wa.size();
    send(0, 8'hA5); send(0, 8'h00); send(0, 8'h02); send(0, 8'h10); send(0, 8'h20); send(0, 8'h31);
    checks++;
    if (wa.size() - base != 2 || wd[base] !== 8'h10 || wa[base+1] !== 13'h1 || wd[base+1] !== 8'h20) begin
      errors++; $display("FAIL bad_writes: got %0d writes want 2 (10@0 20@1)", wa.size() - base);
    end
    checks++;
    if ({b1.load_err, b1.cpu_rst_n, b1.rx_ready, b1.load_busy, b1.mem_sel} !== 5'b10001) begin
      errors++;
      $display("FAIL bad_error: err/rst_n/rdy/busy/sel got %b want 10001", {b1.load_err, b1.cpu_rst_n, b1.rx_ready, b1.load_busy, b1.mem_sel});
    end
  endtask

  task automatic test_garbage_zero_len;
    int base;
    restart(0);
    checks++;
    if (b1.load_err !== 1'b0) begin errors++; $display("FAIL restart_err: got %b want 0", b1.load_err); end
    base = wa.size();
    send(0, 8'h00); send(0, 8'hFF); send(0, 8'h5A);
    checks++;
    if (b1.load_busy !== 1'b0 || b1.rx_ready !== 1'b1) begin
      errors++; $display("FAIL garbage_idle: busy/rdy got %b%b want 01", b1.load_busy, b1.rx_ready);
    end
    send(0, 8'hA5); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    checks++;
    if (wa.size() != base) begin errors++; $display("FAIL zero_len_writes: got %0d want 0", wa.size() - base); end
    checks++;
    if (b1.cpu_rst_n !== 1'b1 || b1.mem_sel !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: rst_n/sel got %b%b want 10", b1.cpu_rst_n, b1.mem_sel);
    end
  endtask

  task automatic test_len_range;
    restart(0);
    send(0, 8'hA5); send(0, 8'h20);
    checks++;
    if (b1.load_err !== 1'b1 || b1.rx_ready !== 1'b0 || b1.cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL len_range_err: err/rdy/rst_n got %b%b%b want 100", b1.load_err, b1.rx_ready, b1.cpu_rst_n);
    end
    restart(0);
    checks++;
    if (b1.load_err !== 1'b0 || b1.rx_ready !== 1'b1) begin
      errors++; $display("FAIL len_range_restart: err/rdy got %b%b want 01", b1.load_err, b1.rx_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int i = 0, first = -1, last = -1, wrc = 0, bad = 0;
    logic rdy;
    restart(1);
    send(1, 8'hA5); send(1, 8'h00); send(1, 8'h04);
    b3.rx_data = pl[0];
    b3.rx_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rdy = b3.rx_ready;
      @(negedge clk);
      if (rdy && i < 4) begin
        if (i == 0) first = c;
        i++;
        if (i < 4) b3.rx_data = pl[i]; else b3.rx_valid = 1'b0;
      end
      if (b3.mem_wr === 1'b1) begin
        wrc++;
        if (b3.rx_ready !== 1'b0) bad++;
      end
      if (i == 4 && last < 0 && b3.mem_wr === 1'b0 && b3.rx_ready === 1'b1) last = c;
    end
    b3.rx_valid = 1'b0;
    checks++;
    if (wrc != 12) begin errors++; $display("FAIL b2b_wr_cycles: got %0d want 12", wrc); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d write cycles with rx_ready=1 want 0", bad); end
    checks++;
    if (last - first != 15) begin errors++; $display("FAIL b2b_span: got %0d cycles want 16", last - first + 1); end
    checks++;
    if (b3.mem_addr !== 13'h3 || b3.mem_wdata !== 8'h04) begin
      errors++; $display("FAIL b2b_last: got %h@%h want 04@0003", b3.mem_wdata, b3.mem_addr);
    end
    send(1, 8'h0A);
    checks++;
    if (b3.cpu_rst_n !== 1'b1 || b3.load_err !== 1'b0) begin
      errors++; $display("FAIL b2b_done: rst_n/err got %b%b want 10", b3.cpu_rst_n, b3.load_err);
    end
  endtask

  task automatic test_abort;
    restart(1);
    send(1, 8'hA5); send(1, 8'h00); send(1, 8'h03); send(1, 8'h77);
    checks++;
    if (b3.mem_wr !== 1'b1) begin errors++; $display("FAIL abort_pre_wr: got %b want 1", b3.mem_wr); end
    restart(1);
    checks++;
    if ({b3.mem_wr, b3.rx_ready, b3.cpu_rst_n, b3.load_busy, b3.mem_sel} !== 5'b01001) begin
      errors++;
      $display("FAIL abort_state: wr/rdy/rst_n/busy/sel got %b want 01001", {b3.mem_wr, b3.rx_ready, b3.cpu_rst_n, b3.load_busy, b3.mem_sel});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b3.mem_wr !== 1'b0) begin errors++; $display("FAIL abort_wr_stays_low: got %b want 0", b3.mem_wr); end
    send(1, 8'hA5); send(1, 8'h00); send(1, 8'h02); send(1, 8'h55);
    checks++;
    if (b3.mem_wr !== 1'b1) begin errors++; $display("FAIL areset_pre_wr: got %b want 1", b3.mem_wr); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b3.mem_wr !== 1'b0 || b3.cpu_rst_n !== 1'b0 || b3.rx_ready !== 1'b0) begin
      errors++; $display("FAIL areset_now: wr/rst_n/rdy got %b%b%b want 000", b3.mem_wr, b3.cpu_rst_n, b3.rx_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (b3.rx_ready !== 1'b1 || b3.load_busy !== 1'b0 || b3.cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL areset_idle: rdy/busy/rst_n got %b%b%b want 100", b3.rx_ready, b3.load_busy, b3.cpu_rst_n);
    end
  endtask

`ifdef BOOT_TIMEOUT_EN
  task automatic test_timeout;
    restart(0);
    send(0, 8'hA5); send(0, 8'h00); send(0, 8'h02); send(0, 8'h11);
    repeat (4) @(negedge clk);
    checks++;
    if (b1.load_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", b1.load_err); end
    repeat (8) @(negedge clk);
    checks++;
    if (b1.load_err !== 1'b1 || b1.cpu_rst_n !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err/rst_n got %b%b want 10", b1.load_err, b1.cpu_rst_n);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_good_frame;
    test_bad_csum;
    test_garbage_zero_len;
    test_len_range;
    test_back_to_back;
    test_abort;
`ifdef BOOT_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1);
  end
endmodule
